hpc1_mul_pipe: RTL and testbench

HPC1_MUL_PIPE -- requirements
Module: hpc1_mul_pipe

---
 rtl/hpc1_mul_pipe.sv | 143 ++++++++++++++
 tb/tb_hpc1_mul_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hpc1_mul_pipe.sv
// Two-stage first-order-secure masked AND (HPC1 style) over NSHARES Boolean shares.
// Stage 1 captures a, the refreshed b' and the pair randomness; stage 2 forms the share products.
module hpc1_mul_pipe #(
    parameter  int NSHARES = 5,
    parameter  int WIDTH   = 8,
    localparam int NPAIR   = NSHARES * (NSHARES - 1) / 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NSHARES*WIDTH-1:0]     a,
    input  logic [NSHARES*WIDTH-1:0]     b,
    input  logic [(NSHARES-1)*WIDTH-1:0] r,
    input  logic [NPAIR*WIDTH-1:0]       p,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NSHARES*WIDTH-1:0]     c
);

    if (NSHARES < 2 || NSHARES > 8) begin : g_bad_nshares
        $error("hpc1_mul_pipe: NSHARES must be in 2..8");
    end

    // XOR of all refresh words; used as the last refresh mask so the masks cancel overall.
    function automatic logic [WIDTH-1:0] fold_r(input logic [(NSHARES-1)*WIDTH-1:0] v);
        logic [WIDTH-1:0] acc;
        acc = {WIDTH{1'b0}};
        for (int k = 0; k < NSHARES - 1; k++) begin
            acc = acc ^ v[k*WIDTH +: WIDTH];
        end
        return acc;
    endfunction

    // Lexicographic index of pair (i,j), i<j, with (0,1) at index 0.
    function automatic int pair_idx(input int i, input int j);
        return i * NSHARES - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    logic                         s1_valid_q, s1_valid_d;
    logic                         out_valid_q, out_valid_d;
    logic [NSHARES*WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [NSHARES*WIDTH-1:0]     s1_b_q, s1_b_d;
    logic [NPAIR*WIDTH-1:0]       s1_p_q, s1_p_d;
    logic [NSHARES*WIDTH-1:0]     c_q, c_d;

    logic                         in_xfer_s;
    logic                         adv_s;
    logic [WIDTH-1:0]             r_last_s;
    logic [NSHARES*WIDTH-1:0]     b_ref_s;
    logic [NSHARES*WIDTH-1:0]     prod_s;
    logic [WIDTH-1:0]             acc_s;
    logic [WIDTH-1:0]             term_s;

    assign adv_s     = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || !out_valid_q || out_ready;
    assign in_xfer_s = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign c         = c_q;

    // Refresh b before it is ever stored; raw b never reaches a register.
    always_comb begin
        r_last_s = fold_r(r);
        b_ref_s  = {NSHARES*WIDTH{1'b0}};
        for (int j = 0; j < NSHARES; j++) begin
            if (j < NSHARES - 1) begin
                b_ref_s[j*WIDTH +: WIDTH] = b[j*WIDTH +: WIDTH] ^ r[j*WIDTH +: WIDTH];
            end else begin
                b_ref_s[j*WIDTH +: WIDTH] = b[j*WIDTH +: WIDTH] ^ r_last_s;
            end
        end
    end

    // Share products from registered stage-1 values only; cross terms are masked by p before folding.
    always_comb begin
        prod_s = {NSHARES*WIDTH{1'b0}};
        acc_s  = {WIDTH{1'b0}};
        term_s = {WIDTH{1'b0}};
        for (int i = 0; i < NSHARES; i++) begin
            acc_s = {WIDTH{1'b0}};
            for (int j = 0; j < NSHARES; j++) begin
                term_s = s1_a_q[i*WIDTH +: WIDTH] & s1_b_q[j*WIDTH +: WIDTH];
                if (i < j) begin
                    term_s = term_s ^ s1_p_q[pair_idx(i, j)*WIDTH +: WIDTH];
                end else if (i > j) begin
                    term_s = term_s ^ s1_p_q[pair_idx(j, i)*WIDTH +: WIDTH];
                end else begin
                    term_s = term_s;
                end
                acc_s = acc_s ^ term_s;
            end
            prod_s[i*WIDTH +: WIDTH] = acc_s;
        end
    end

    // Next-state selection: data registers only move on their own stage's load.
    always_comb begin
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_p_d      = s1_p_q;
        s1_valid_d  = s1_valid_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        if (in_xfer_s) begin
            s1_a_d     = a;
            s1_b_d     = b_ref_s;
            s1_p_d     = p;
            s1_valid_d = 1'b1;
        end else if (adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (adv_s) begin
            c_d         = prod_s;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset drops any bundle in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_a_q      <= {NSHARES*WIDTH{1'b0}};
            s1_b_q      <= {NSHARES*WIDTH{1'b0}};
            s1_p_q      <= {NPAIR*WIDTH{1'b0}};
            c_q         <= {NSHARES*WIDTH{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_p_q      <= s1_p_d;
            c_q         <= c_d;
        end
    end

endmodule

// File: tb/tb_hpc1_mul_pipe.sv
// Scoreboard bench for hpc1_mul_pipe: the reference is the unmasked product (XOR a) & (XOR b).
module tb_hpc1_mul_pipe;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int NP = N * (N - 1) / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [N*W-1:0]    a, b, c;
    logic [(N-1)*W-1:0] r;
    logic [NP*W-1:0]   p;

    logic              in_valid2, in_ready2, out_valid2, out_ready2;
    logic [2*W-1:0]    a2, b2, c2;
    logic [W-1:0]      r2, p2;

    hpc1_mul_pipe #(.NSHARES(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .r(r), .p(p),
        .out_valid(out_valid), .out_ready(out_ready), .c(c));

    hpc1_mul_pipe #(.NSHARES(2), .WIDTH(W)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .r(r2), .p(p2),
        .out_valid(out_valid2), .out_ready(out_ready2), .c(c2));

    typedef struct { logic [W-1:0] v; int cyc; } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  stalls = 0;
    bit  lat_check = 1'b0;
    bit  rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [N*W-1:0] v);
        logic [W-1:0] x;
        x = '0;
        for (int k = 0; k < N; k++) x = x ^ v[k*W +: W];
        return x;
    endfunction

    function automatic logic [N*W-1:0] rnd_shares();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [(N-1)*W-1:0] rnd_r();
        logic [(N-1)*W-1:0] v;
        for (int k = 0; k < N - 1; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [NP*W-1:0] rnd_p();
        logic [NP*W-1:0] v;
        for (int k = 0; k < NP; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    // Output monitor: every presented result must match the oldest outstanding bundle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got result 0x%0h, want no output", fold(c));
            end else begin
                e = exp_q.pop_front();
                check("xor_c", 64'(fold(c)), 64'(e.v));
                if (lat_check) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                         input logic [(N-1)*W-1:0] rv, input logic [NP*W-1:0] pv);
        int tries;
        bit done;
        a = av; b = bv; r = rv; p = pv;
        in_valid = 1'b1;
        tries = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{v: fold(av) & fold(bv), cyc: cyc});
                done = 1'b1;
            end else begin
                stalls++;
            end
            tick();
            tries++;
            if (!done && tries > 200) begin
                total++;
                bad++;
                $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, want acceptance", tries);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    logic [N*W-1:0] hold_c;
    bit             got_hold;
    bit             took;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; r = '0; p = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        a2 = '0; b2 = '0; r2 = '0; p2 = '0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", 64'(c), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-share worked example
        a2 = {8'hF0, 8'h0F}; b2 = {8'h00, 8'h33}; r2 = 8'h55; p2 = 8'hAA;
        in_valid2 = 1'b1;
        @(negedge clk);
        check("ex_in_ready", 64'(in_ready2), 64'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        a2 = 16'h1234; b2 = 16'h5678; r2 = 8'h9A; p2 = 8'hBC;
        @(negedge clk);
        check("ex_out_valid_c1", 64'(out_valid2), 64'd0);
        @(negedge clk);
        check("ex_out_valid_c2", 64'(out_valid2), 64'd1);
        check("ex_c0", 64'(c2[7:0]), 64'hA9);
        check("ex_c1", 64'(c2[15:8]), 64'h9A);
        check("ex_xor", 64'(c2[7:0] ^ c2[15:8]), 64'h33);
        @(negedge clk);
        check("ex_consumed", 64'(out_valid2), 64'd0);
        @(posedge clk); #1;

        // Back-to-back stream, no backpressure
        lat_check = 1'b1;
        stalls = 0;
        for (int i = 0; i < 8; i++) issue(rnd_shares(), rnd_shares(), rnd_r(), rnd_p());
        repeat (4) tick();
        check("b2b_stalls", 64'(stalls), 64'd0);
        check("b2b_drained", 64'(exp_q.size()), 64'd0);
        lat_check = 1'b0;

        // Backpressure with a continuous stream, then idle-input toggling while full
        out_ready = 1'b0;
        got_hold = 1'b0;
        a = rnd_shares(); b = rnd_shares(); r = rnd_r(); p = rnd_p();
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (k >= 2) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                if (!got_hold) begin
                    hold_c = c;
                    got_hold = 1'b1;
                end else begin
                    check("stall_c_hold", 64'(c), 64'(hold_c));
                end
            end
            if (took) exp_q.push_back('{v: fold(a) & fold(b), cyc: cyc});
            @(posedge clk); #1;
            if (took) begin
                a = rnd_shares(); b = rnd_shares(); r = rnd_r(); p = rnd_p();
            end
        end
        check("stall_accepted", 64'(exp_q.size()), 64'd2);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = rnd_shares(); b = rnd_shares(); r = rnd_r(); p = rnd_p();
            @(negedge clk);
            check("idle_c_hold", 64'(c), 64'(hold_c));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        issue(rnd_shares(), rnd_shares(), rnd_r(), rnd_p());
        issue(rnd_shares(), rnd_shares(), rnd_r(), rnd_p());
        @(negedge clk);
        check("prereset_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_c", 64'(c), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        lat_check = 1'b1;
        issue(rnd_shares(), rnd_shares(), rnd_r(), rnd_p());
        repeat (3) tick();
        lat_check = 1'b0;

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            issue(rnd_shares(), rnd_shares(), rnd_r(), rnd_p());
        end

        // Zero refresh and pair randomness
        for (int i = 0; i < 300; i++) begin
            issue(rnd_shares(), rnd_shares(), '0, '0);
        end

        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
